// File: rtl/seq_checker.sv
// Round checker for the memory game: latches the LED target, collects one masked bit per
// step, compares after WIDTH steps and keeps a saturating streak. Option: SEQ_CHECK_EARLY_FAIL_EN.
module seq_checker #(
   parameter int WIDTH       = 8,
   parameter int SCORE_W     = 4,
   parameter int RESULT_HOLD = 50
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   target_i,
   input  logic               step_vld_i,
   input  logic [WIDTH-1:0]   seq_in_i,
   output logic               busy_o,
   output logic               match_o,
   output logic               miss_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [WIDTH-1:0]   acc_o
);

   localparam int IDX_W  = $clog2(WIDTH) + 1;
   localparam int HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
   localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RESULT_HOLD - 1);
   localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0]  HOLD_ZERO = {HOLD_W{1'b0}};
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_CHECK   = 3'd2,
      ST_PASS    = 3'd3,
      ST_FAIL    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   tgt_q, tgt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               busy_q, match_q, miss_q;
   logic [WIDTH-1:0]   mask_s;
   logic               restart_s;
   logic               last_step_s;

   // One-hot selector for the step position; positions at or beyond WIDTH select nothing.
   function automatic logic [WIDTH-1:0] step_mask(input logic [IDX_W-1:0] idx);
      logic [WIDTH-1:0] m;
      m = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         m[i] = (idx == IDX_W'(i));
      end
      return m;
   endfunction

   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
      logic [SCORE_W-1:0] r;
      if (s == SCORE_MAX) begin
         r = SCORE_MAX;
      end else begin
         r = s + SCORE_ONE;
      end
      return r;
   endfunction

   assign mask_s      = step_mask(idx_q);
   assign restart_s   = start_i && (state_q != ST_CHECK);
   assign last_step_s = (idx_q == LAST_IDX);

`ifdef SEQ_CHECK_EARLY_FAIL_EN
   logic step_bad_s;
   assign step_bad_s = |((seq_in_i ^ tgt_q) & mask_s);
`endif

   // Next-state and datapath update; START outranks any step in the same cycle.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      score_d = score_q;
      if (restart_s) begin
         state_d = ST_COLLECT;
         tgt_d   = target_i;
         acc_d   = {WIDTH{1'b0}};
         idx_d   = {IDX_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_COLLECT: begin
               if (step_vld_i) begin
                  acc_d = acc_q | (seq_in_i & mask_s);
                  idx_d = idx_q + IDX_ONE;
`ifdef SEQ_CHECK_EARLY_FAIL_EN
                  if (step_bad_s) begin
                     state_d = ST_FAIL;
                     score_d = {SCORE_W{1'b0}};
                     hold_d  = HOLD_INIT;
                  end else if (last_step_s) begin
                     state_d = ST_CHECK;
                  end else begin
                     state_d = ST_COLLECT;
                  end
`else
                  if (last_step_s) begin
                     state_d = ST_CHECK;
                  end else begin
                     state_d = ST_COLLECT;
                  end
`endif
               end else begin
                  state_d = ST_COLLECT;
               end
            end
            ST_CHECK: begin
               hold_d = HOLD_INIT;
               if (acc_q == tgt_q) begin
                  state_d = ST_PASS;
                  score_d = score_inc(score_q);
               end else begin
                  state_d = ST_FAIL;
                  score_d = {SCORE_W{1'b0}};
               end
            end
            ST_PASS, ST_FAIL: begin
               if (hold_q == HOLD_ZERO) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = hold_q - HOLD_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; flags are registered from the next state so they align with it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         tgt_q   <= {WIDTH{1'b0}};
         acc_q   <= {WIDTH{1'b0}};
         idx_q   <= {IDX_W{1'b0}};
         hold_q  <= {HOLD_W{1'b0}};
         score_q <= {SCORE_W{1'b0}};
         busy_q  <= 1'b0;
         match_q <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         score_q <= score_d;
         busy_q  <= (state_d == ST_COLLECT) || (state_d == ST_CHECK);
         match_q <= (state_d == ST_PASS);
         miss_q  <= (state_d == ST_FAIL);
      end
   end

   assign busy_o  = busy_q;
   assign match_o = match_q;
   assign miss_o  = miss_q;
   assign score_o = score_q;
   assign acc_o   = acc_q;

endmodule
